// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the uRV bring-up memory model.
package rv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_WAIT  = 2'd1,
      STORE_WAIT = 2'd2,
      DONE       = 2'd3
   } t_dm_state;

   // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
   localparam logic [15:0] c_lfsr_taps = 16'hB400;

   localparam logic [31:0] c_console_default_addr = 32'h0010_0000;

endpackage

// File: rtl/rv_lfsr16.sv
// 16-bit Fibonacci LFSR used to generate reproducible stall patterns.
module rv_lfsr16
   import rv_mem_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] seed_i,
   input  logic        enable_i,
   output logic [15:0] out_o
);

   logic [15:0] r_lfsr;
   logic        w_feedback;

   assign w_feedback = ^(r_lfsr & c_lfsr_taps);

   // Shift left, feeding the tap parity into bit 0; reload the seed on reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lfsr <= seed_i;
      end else if (enable_i) begin
         r_lfsr <= {r_lfsr[14:0], w_feedback};
      end
   end

   assign out_o = r_lfsr;

endmodule

// File: rtl/rv_sim_memory.sv
// Memory model for uRV bring-up: fetch port plus load/store port sharing one
// word-addressed RAM, with a console TX register mapped at g_console_addr.
// Optional random stalls are built when RV_SIM_MEMORY_RANDOM_STALL_EN is defined.
//
// Data port FSM:
//   state      | meaning
//   IDLE       | ready for a request; store wins when both are raised
//   LOAD_WAIT  | counting down load wait cycles
//   STORE_WAIT | counting down store wait cycles
//   DONE       | done pulse visible; store commits at the end of this cycle
module rv_sim_memory
   import rv_mem_pkg::*;
#(
   parameter int unsigned g_mem_words     = 16384,
   parameter string       g_init_file     = "",
   parameter int unsigned g_im_wait       = 0,
   parameter int unsigned g_dm_load_wait  = 0,
   parameter int unsigned g_dm_store_wait = 0,
   parameter logic [31:0] g_console_addr  = c_console_default_addr,
   parameter logic [15:0] g_stall_seed    = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] im_addr_i,
   output logic [31:0] im_data_o,
   output logic        im_valid_o,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_store_i,
   input  logic        dm_load_i,
   output logic [31:0] dm_data_l_o,
   output logic        dm_ready_o,
   output logic        dm_load_done_o,
   output logic        dm_store_done_o,
   output logic        con_tx_valid_o,
   output logic [7:0]  con_tx_data_o
);

   localparam int unsigned c_idx_w   = $clog2(g_mem_words);
   localparam logic [3:0]  c_im_wait = 4'(g_im_wait);
   localparam logic [3:0]  c_ld_wait = 4'(g_dm_load_wait);
   localparam logic [3:0]  c_st_wait = 4'(g_dm_store_wait);

   logic [31:0] r_mem [g_mem_words];

   logic w_im_stall;
   logic w_dm_stall;

`ifdef RV_SIM_MEMORY_RANDOM_STALL_EN
   logic [15:0] w_lfsr;

   rv_lfsr16 u_lfsr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .seed_i   (g_stall_seed),
      .enable_i (1'b1),
      .out_o    (w_lfsr)
   );

   assign w_im_stall = w_lfsr[0];
   assign w_dm_stall = w_lfsr[1];
`else
   assign w_im_stall = 1'b0;
   assign w_dm_stall = 1'b0;
`endif

   // ---------------- fetch port ----------------
   logic [31:0] r_im_addr_prev;
   logic [31:0] r_im_data;
   logic [3:0]  r_im_cnt;
   logic [3:0]  w_im_cnt_nxt;
   logic        r_im_valid;

   // Reload the wait counter on an address change, otherwise run it down to 0
   always_comb begin
      w_im_cnt_nxt = r_im_cnt;
      if (im_addr_i != r_im_addr_prev) begin
         w_im_cnt_nxt = c_im_wait;
      end else if (r_im_cnt != 4'd0) begin
         w_im_cnt_nxt = r_im_cnt - 4'd1;
      end
   end

   // Registered fetch: data for this cycle's address appears next cycle,
   // flagged valid once its wait count has expired
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_im_addr_prev <= 32'd0;
         r_im_cnt       <= 4'd0;
         r_im_valid     <= 1'b0;
         r_im_data      <= 32'd0;
      end else begin
         r_im_addr_prev <= im_addr_i;
         r_im_cnt       <= w_im_cnt_nxt;
         r_im_valid     <= (w_im_cnt_nxt == 4'd0);
         r_im_data      <= r_mem[im_addr_i[c_idx_w+1:2]];
      end
   end

   assign im_data_o  = r_im_data;
   assign im_valid_o = r_im_valid & ~w_im_stall;

   // ---------------- data port ----------------
   t_dm_state          r_dm_state;
   logic [31:0]        r_dm_addr;
   logic [31:0]        r_dm_wdata;
   logic [3:0]         r_dm_sel;
   logic [3:0]         r_dm_cnt;
   logic [31:0]        r_dm_rdata;
   logic               r_ld_done;
   logic               r_st_done;
   logic               r_con_valid;
   logic [7:0]         r_con_data;
   logic               w_dm_ready;
   logic               w_is_console;
   logic [c_idx_w-1:0] w_dm_idx;

   assign w_dm_ready   = (r_dm_state == IDLE) && !w_dm_stall && !rst_i;
   assign w_dm_idx     = r_dm_addr[c_idx_w+1:2];
   assign w_is_console = (r_dm_addr == g_console_addr);

   // Request handshake FSM; done pulses, load data and console byte are
   // registered on entry to DONE so they are visible during that cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_dm_state  <= IDLE;
         r_dm_addr   <= 32'd0;
         r_dm_wdata  <= 32'd0;
         r_dm_sel    <= 4'd0;
         r_dm_cnt    <= 4'd0;
         r_dm_rdata  <= 32'd0;
         r_ld_done   <= 1'b0;
         r_st_done   <= 1'b0;
         r_con_valid <= 1'b0;
         r_con_data  <= 8'd0;
      end else begin
         r_ld_done   <= 1'b0;
         r_st_done   <= 1'b0;
         r_con_valid <= 1'b0;
         unique case (r_dm_state)
            IDLE: begin
               if (w_dm_ready && (dm_store_i || dm_load_i)) begin
                  r_dm_addr  <= dm_addr_i;
                  r_dm_wdata <= dm_data_s_i;
                  r_dm_sel   <= dm_data_select_i;
                  if (dm_store_i) begin
                     r_dm_state <= STORE_WAIT;
                     r_dm_cnt   <= c_st_wait;
                  end else begin
                     r_dm_state <= LOAD_WAIT;
                     r_dm_cnt   <= c_ld_wait;
                  end
               end
            end
            LOAD_WAIT: begin
               if (r_dm_cnt == 4'd0) begin
                  r_dm_state <= DONE;
                  r_ld_done  <= 1'b1;
                  r_dm_rdata <= w_is_console ? 32'd0 : r_mem[w_dm_idx];
               end else begin
                  r_dm_cnt <= r_dm_cnt - 4'd1;
               end
            end
            STORE_WAIT: begin
               if (r_dm_cnt == 4'd0) begin
                  r_dm_state <= DONE;
                  r_st_done  <= 1'b1;
                  if (w_is_console) begin
                     r_con_valid <= 1'b1;
                     r_con_data  <= r_dm_wdata[7:0];
                  end
               end else begin
                  r_dm_cnt <= r_dm_cnt - 4'd1;
               end
            end
            DONE: begin
               r_dm_state <= IDLE;
            end
            default: begin
               r_dm_state <= IDLE;
            end
         endcase
      end
   end

   // Commit the selected bytes at the end of a store's DONE cycle; a reset in
   // DONE suppresses the write, and console stores never touch the RAM
   always_ff @(posedge clk_i) begin
      if (r_st_done && !w_is_console && !rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (r_dm_sel[b]) begin
               r_mem[w_dm_idx][8*b +: 8] <= r_dm_wdata[8*b +: 8];
            end
         end
      end
   end

   // Pulses are masked by reset so an aborted operation never reports completion
   assign dm_ready_o      = w_dm_ready;
   assign dm_load_done_o  = r_ld_done & ~rst_i;
   assign dm_store_done_o = r_st_done & ~rst_i;
   assign con_tx_valid_o  = r_con_valid & ~rst_i;
   assign con_tx_data_o   = r_con_data;
   assign dm_data_l_o     = r_dm_rdata;

endmodule

// File: tb/tb_rv_sim_memory.sv
// Self-checking bench for rv_sim_memory: directed fetch/byte/wrap/console/reset
// cases followed by random loads and stores against a scoreboard.
module tb_rv_sim_memory;

   localparam int          WORDS = 16;
   localparam int          IMW   = 2;
   localparam int          LDW   = 1;
   localparam int          STW   = 2;
   localparam logic [31:0] CON   = 32'h0010_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] im_addr = 32'd0;
   logic [31:0] im_data;
   logic        im_valid;
   logic [31:0] dm_addr = 32'd0;
   logic [31:0] dm_wdata = 32'd0;
   logic [3:0]  dm_sel = 4'd0;
   logic        dm_store = 1'b0;
   logic        dm_load = 1'b0;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        ld_done;
   logic        st_done;
   logic        con_valid;
   logic [7:0]  con_data;

   rv_sim_memory #(
      .g_mem_words     (WORDS),
      .g_init_file     (""),
      .g_im_wait       (IMW),
      .g_dm_load_wait  (LDW),
      .g_dm_store_wait (STW),
      .g_console_addr  (CON),
      .g_stall_seed    (16'hACE1)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .im_addr_i        (im_addr),
      .im_data_o        (im_data),
      .im_valid_o       (im_valid),
      .dm_addr_i        (dm_addr),
      .dm_data_s_i      (dm_wdata),
      .dm_data_select_i (dm_sel),
      .dm_store_i       (dm_store),
      .dm_load_i        (dm_load),
      .dm_data_l_o      (dm_rdata),
      .dm_ready_o       (dm_ready),
      .dm_load_done_o   (ld_done),
      .dm_store_done_o  (st_done),
      .con_tx_valid_o   (con_valid),
      .con_tx_data_o    (con_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;
   int n_con  = 0;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      bit          is_st;
      bit          con;
   } sb_t;

   sb_t         sb [$];
   logic [31:0] model [WORDS];
   logic [31:0] last_ld = 32'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (con_valid) n_con++;
      if (ld_done || st_done) begin
         if (sb.size() == 0) begin
            check_val("unexpected_done", {30'd0, ld_done, st_done}, 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check_val("done_cycle", cyc, e.cyc);
            check_val("done_kind", {31'd0, st_done}, {31'd0, e.is_st});
            if (!e.is_st) begin
               check_val("load_data", dm_rdata, e.data);
            end else begin
               check_val("con_valid", {31'd0, con_valid}, {31'd0, e.con});
               if (e.con) check_val("con_data", {24'd0, con_data}, {24'd0, e.data[7:0]});
            end
         end
      end else if (con_valid) begin
         check_val("stray_con", {31'd0, con_valid}, 32'd0);
      end
   end

   task automatic dm_op(input bit st, input bit ld, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      sb_t e;
      bit  ok;
      @(posedge clk); #1;
      dm_addr = a; dm_wdata = d; dm_sel = s; dm_store = st; dm_load = ld;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (dm_ready) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      check_val("accept", {31'd0, ok}, 32'd1);
      e.is_st = st;
      e.con   = st && (a == CON);
      if (st) begin
         e.cyc  = cyc + 2 + STW;
         e.data = d;
         if (!e.con) model[a[5:2]] = merge(model[a[5:2]], d, s);
      end else begin
         e.cyc   = cyc + 2 + LDW;
         e.data  = (a == CON) ? 32'd0 : model[a[5:2]];
         last_ld = e.data;
      end
      if (ok) sb.push_back(e);
      @(posedge clk); #1;
      dm_store = 1'b0; dm_load = 1'b0;
      for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
      check_val("drain", sb.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_im_data"}, im_data, 32'd0);
      check_val({tag, "_im_valid"}, {31'd0, im_valid}, 32'd0);
      check_val({tag, "_dm_rdata"}, dm_rdata, 32'd0);
      check_val({tag, "_ready"}, {31'd0, dm_ready}, 32'd0);
      check_val({tag, "_dones"}, {30'd0, ld_done, st_done}, 32'd0);
      check_val({tag, "_con"}, {23'd0, con_valid, con_data}, 32'd0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end

   initial begin
      int  con_before;
      bit  ok;
      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1 rst = 1'b0;

      // initialise every word so later loads have known contents
      for (int i = 0; i < WORDS; i++) dm_op(1, 0, 32'(i * 4), 32'hFFFF_0000 | 32'(i), 4'hF);
      dm_op(1, 0, 32'h10, 32'hDEADBEEF, 4'hF);
      dm_op(1, 0, 32'h20, 32'hFFFFFFFF, 4'hF);

      // fetch: address step 0x0 -> 0x10 with two wait cycles
      repeat (4) @(posedge clk);
      #1 im_addr = 32'h10;
`ifndef RV_SIM_MEMORY_RANDOM_STALL_EN
      @(negedge clk); check_val("fetch_prev_valid", {31'd0, im_valid}, 32'd1);
      @(negedge clk); check_val("fetch_wait1", {31'd0, im_valid}, 32'd0);
      @(negedge clk); check_val("fetch_wait2", {31'd0, im_valid}, 32'd0);
      @(negedge clk); check_val("fetch_valid", {31'd0, im_valid}, 32'd1);
`else
      repeat (4) @(negedge clk);
`endif
      check_val("fetch_data", im_data, 32'hDEADBEEF);

      // byte-select store then load
      dm_op(1, 0, 32'h20, 32'h11223344, 4'b0101);
      dm_op(0, 1, 32'h20, 32'd0, 4'd0);
      check_val("byte_sel", dm_rdata, 32'hFF22FF44);

      // wrap: 0x40 aliases word 0 in a 16-word RAM
      dm_op(1, 0, 32'h40, 32'hCAFE0001, 4'hF);
      check_val("load_hold", dm_rdata, 32'hFF22FF44);
      dm_op(0, 1, 32'h0, 32'd0, 4'd0);
      check_val("wrap", dm_rdata, 32'hCAFE0001);

      // console store: strobe once, RAM (word 0 alias) untouched
      con_before = n_con;
      dm_op(1, 0, CON, 32'h00000041, 4'hF);
      check_val("con_count", n_con - con_before, 32'd1);
      check_val("con_byte", {24'd0, con_data}, 32'h41);
      dm_op(0, 1, 32'h0, 32'd0, 4'd0);
      check_val("con_ram_kept", dm_rdata, 32'hCAFE0001);
      dm_op(0, 1, CON, 32'd0, 4'd0);

      // fetch of a word being committed: old in the commit cycle, new later
      fork
         dm_op(1, 0, 32'h10, 32'h12345678, 4'hF);
         begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 30; t++) begin
               @(negedge clk);
               if (st_done) begin seen = 1'b1; break; end
            end
            check_val("commit_seen", {31'd0, seen}, 32'd1);
            check_val("fetch_commit_old", im_data, 32'hDEADBEEF);
            @(negedge clk); @(negedge clk);
            check_val("fetch_commit_new", im_data, 32'h12345678);
         end
      join

      // simultaneous load+store, reset during STORE_WAIT aborts it
      @(posedge clk); #1;
      dm_addr = 32'h24; dm_wdata = 32'h55AA55AA; dm_sel = 4'hF; dm_store = 1'b1; dm_load = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (dm_ready) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      check_val("rst_accept", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      dm_store = 1'b0; dm_load = 1'b0; rst = 1'b1;
      @(negedge clk);
      check_val("rst_no_done", {29'd0, ld_done, st_done, con_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("abort");
      @(posedge clk); #1 rst = 1'b0;
      last_ld = 32'd0;
      @(negedge clk);
      check_val("ready_after_rst", {31'd0, dm_ready}, 32'd1);
      repeat (6) @(negedge clk);
      check_val("abort_sb_empty", sb.size(), 32'd0);
      dm_op(0, 1, 32'h24, 32'd0, 4'd0);

`ifdef RV_SIM_MEMORY_RANDOM_STALL_EN
      begin
         logic [31:0] pat [2];
         for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            for (int i = 0; i < 32; i++) begin @(negedge clk); pat[r][i] = dm_ready; end
         end
         check_val("stall_repeat", pat[1], pat[0]);
         last_ld = 32'd0;
      end
`endif

      // random loads and stores
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] a;
         int          k;
         k = $urandom_range(0, 2);
         if ($urandom_range(0, 9) == 0) a = CON;
         else a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
         dm_op(k != 0, k != 1, a, $urandom, 4'($urandom_range(0, 15)));
      end
      check_val("final_hold", dm_rdata, last_ld);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
